mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the core's single memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage, driven by `MemRead`/`MemWrite`/`MemSize`). One transaction is outstanding at a time. Data accesses have priority, bounded by a starvation limit so fetch always progresses. The arbiter latches each granted request, drives it to memory until completion, and routes the completion pulse and read data back to the granted requester.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch is waiting; range 1..15.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  fetch request pending.
- `i_addr`  in  64  fetch address, 4-byte aligned.
- `i_ok`  out  1  one-cycle fetch completion pulse.
- `i_data`  out  32  fetched instruction; valid when `i_ok`.
- `d_valid`  in  1  data request pending.
- `d_write`  in  1  1 = store, 0 = load.
- `d_addr`  in  64  data address.
- `d_size`  in  3  access size, MemSizeType encoding: 1 = 8b, 2 = 16b, 3 = 32b, 4 = 64b.
- `d_wdata`  in  64  store data, lane-aligned.
- `d_strobe`  in  8  byte-enable mask for stores.
- `d_ok`  out  1  one-cycle data completion pulse.
- `d_rdata`  out  64  load data; valid when `d_ok`.
- `m_valid`  out  1  memory request active.
- `m_write`, `m_addr` (64), `m_size` (3), `m_wdata` (64), `m_strobe` (8)  out  latched request fields.
- `m_ok`  in  1  memory completion; single-cycle pulse.
- `m_rdata`  in  64  memory read data; valid when `m_ok`.

## Operation
- FSM states:
  - IDLE: no transaction.
  - BUSY_I: fetch transaction in flight.
  - BUSY_D: data transaction in flight.
- Grant decision, evaluated in IDLE only:
  - Grant D if `d_valid` and (`!i_valid` or `starve_cnt < STARVE_LIMIT`).
  - Otherwise grant I if `i_valid`.
  - Otherwise stay in IDLE.
- On grant, latch `addr`, `size`, `write`, `wdata` and `strobe` into `m_*` registers. A fetch uses `size` = 3, `write` = 0, `strobe` = 0, `wdata` = 0.
- In BUSY_x: `m_valid` = 1 and `m_*` hold the latched values. On `m_ok`:
  - The granted requester gets its `*_ok` pulse.
  - The FSM returns to IDLE.
- `i_data` = `m_rdata[63:32]` if the latched `addr[2]` = 1, else `m_rdata[31:0]`.
- `d_rdata` = `m_rdata` unmodified. The MEM stage performs lane extraction and extension.
- `starve_cnt` (4 bits):
  - Incremented, saturating at `STARVE_LIMIT`, on a D grant while `i_valid` = 1.
  - Cleared on an I grant, or on a D grant while `i_valid` = 0.
- Requesters hold `valid` and fields stable until their `*_ok`. Input changes after grant are ignored.
- If a requester drops `valid` mid-transaction, the transaction still completes and `*_ok` still pulses.
- `*_ok` never pulses for the non-granted requester. `i_ok` and `d_ok` are never high together.
- `m_ok` while in IDLE is ignored: no output pulse, no state change.
- `d_size` values 0, 5, 6, 7 are forwarded unchanged. They are illegal, and no checking is done.

## Timing
- Reset: state = IDLE, `starve_cnt` = 0. All outputs are 0: `m_valid`, `m_*`, `i_ok`, `d_ok`, `i_data`, `d_rdata`.
- Reset asserted mid-transaction aborts it:
  - State returns to IDLE.
  - `m_valid` = 0 from the next cycle.
  - No `*_ok` is issued.
  - Memory is reset by the same `reset`.
- Request seen in IDLE at cycle t → `m_valid` = 1 from cycle t+1.
- `m_ok` at cycle k → `*_ok` and data combinationally in cycle k; state is IDLE at k+1.
- Back-to-back requests: the next grant is evaluated at k+1, so the next `m_valid` is at k+2. There is one idle bubble between transactions.
- Minimum transaction, with `m_ok` in the first busy cycle: 2 cycles from request to `*_ok`.
- `*_ok` and `*_data` are combinational from `m_ok`/`m_rdata` and the registered state. All other outputs are registered.

## Test plan
- Fetch only: `i_valid` = 1, `i_addr` = 0x8000_0004; memory returns `m_rdata` = 0x1111_2222_3333_4444 after 3 cycles → `m_addr` = 0x8000_0004, `m_size` = 3, `i_ok` pulses once, `i_data` = 0x1111_2222.
- Simultaneous requests, `starve_cnt` = 0 → D granted first. Store: `d_addr` = 0x100, `d_strobe` = 0x0F, `d_wdata` = 0xDEAD_BEEF, `m_write` = 1. After `d_ok`, I is granted at the next IDLE evaluation only if `d_valid` = 0 or the limit is reached.
- Starvation: `i_valid` and `d_valid` held high continuously, `STARVE_LIMIT` = 4, `m_ok` after 1 cycle → grant order D, D, D, D, I, D…; `starve_cnt` returns to 0 after the I grant.
- Input mutation: change `d_addr` from 0x200 to 0x300 during BUSY_D → `m_addr` stays 0x200 until `m_ok`.
- Reset mid-BUSY_I: assert `reset` one cycle → next cycle `m_valid` = 0, no `i_ok`. After deassert, a fresh `d_valid` is granted normally.
- Spurious `m_ok` in IDLE → no `i_ok`/`d_ok`, state stays IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Ports: clk/reset; i_* fetch side; d_* data side; m_* memory side.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic        d_write,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_strobe,
  output logic        d_ok,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic        m_write,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_strobe,
  input  logic        m_ok,
  input  logic [63:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_nxt;
  logic        grant_d;
  logic        grant_i;

  logic        write_nxt;
  logic [63:0] addr_nxt;
  logic [2:0]  size_nxt;
  logic [63:0] wdata_nxt;
  logic [7:0]  strobe_nxt;

  always_comb begin
    grant_d = d_valid && (!i_valid || (starve_cnt < LIMIT));
    grant_i = !grant_d && i_valid;
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    write_nxt  = m_write;
    addr_nxt   = m_addr;
    size_nxt   = m_size;
    wdata_nxt  = m_wdata;
    strobe_nxt = m_strobe;
    case (state)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            state_nxt  = BUSY_D;
            write_nxt  = d_write;
            addr_nxt   = d_addr;
            size_nxt   = d_size;
            wdata_nxt  = d_wdata;
            strobe_nxt = d_strobe;
            // Only count data grants that made a fetch wait.
            if (!i_valid) begin
              starve_nxt = 4'd0;
            end else if (starve_cnt < LIMIT) begin
              starve_nxt = starve_cnt + 4'd1;
            end
          end
          grant_i: begin
            state_nxt  = BUSY_I;
            write_nxt  = 1'b0;
            addr_nxt   = i_addr;
            size_nxt   = 3'd3;
            wdata_nxt  = 64'd0;
            strobe_nxt = 8'd0;
            starve_nxt = 4'd0;
          end
          default: begin
            state_nxt = IDLE;
          end
        endcase
      end
      BUSY_I, BUSY_D: begin
        if (m_ok) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      m_write    <= 1'b0;
      m_addr     <= 64'd0;
      m_size     <= 3'd0;
      m_wdata    <= 64'd0;
      m_strobe   <= 8'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      m_write    <= write_nxt;
      m_addr     <= addr_nxt;
      m_size     <= size_nxt;
      m_wdata    <= wdata_nxt;
      m_strobe   <= strobe_nxt;
    end
  end

  assign m_valid = (state != IDLE);

  // A completion racing a reset is dropped: the transaction is aborted.
  assign i_ok = (state == BUSY_I) && m_ok && !reset;
  assign d_ok = (state == BUSY_D) && m_ok && !reset;

  assign i_data  = !i_ok ? 32'd0 :
                   m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
  assign d_rdata = d_ok ? m_rdata : 64'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// Transaction-level model checked every cycle plus directed literals.
module tb_mem_bus_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic        d_write;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [63:0] d_wdata;
  logic [7:0]  d_strobe;
  logic        d_ok;
  logic [63:0] d_rdata;
  logic        m_valid;
  logic        m_write;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [63:0] m_wdata;
  logic [7:0]  m_strobe;
  logic        m_ok;
  logic [63:0] m_rdata;

  mem_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr),
    .i_ok(i_ok), .i_data(i_data),
    .d_valid(d_valid), .d_write(d_write),
    .d_addr(d_addr), .d_size(d_size),
    .d_wdata(d_wdata), .d_strobe(d_strobe),
    .d_ok(d_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_write(m_write),
    .m_addr(m_addr), .m_size(m_size),
    .m_wdata(m_wdata), .m_strobe(m_strobe),
    .m_ok(m_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  string log_s = "";

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: who owns the bus (0 none, 1 fetch, 2 data),
  // the request it was granted with, and how many data
  // grants in a row have jumped ahead of a waiting fetch.
  int          owner = 0;
  int          streak = 0;
  bit          started = 0;
  logic        l_write;
  logic [63:0] l_addr;
  logic [2:0]  l_size;
  logic [63:0] l_wdata;
  logic [7:0]  l_strobe;

  always @(posedge clk) begin
    if (reset) begin
      started  <= 1;
      owner    <= 0;
      streak   <= 0;
      l_write  <= 0;
      l_addr   <= 0;
      l_size   <= 0;
      l_wdata  <= 0;
      l_strobe <= 0;
    end else if (owner != 0) begin
      if (m_ok) owner <= 0;
    end else if (d_valid && (!i_valid || streak < LIM)) begin
      owner    <= 2;
      l_write  <= d_write;
      l_addr   <= d_addr;
      l_size   <= d_size;
      l_wdata  <= d_wdata;
      l_strobe <= d_strobe;
      streak   <= i_valid ? ((streak < LIM) ? streak + 1 : streak) : 0;
    end else if (i_valid) begin
      owner    <= 1;
      l_write  <= 0;
      l_addr   <= i_addr;
      l_size   <= 3;
      l_wdata  <= 0;
      l_strobe <= 0;
      streak   <= 0;
    end
  end

  always @(negedge clk) begin
    logic ei, ed;
    logic [31:0] eword;
    if (started) begin
      ei = (owner == 1) && m_ok && !reset;
      ed = (owner == 2) && m_ok && !reset;
      eword = l_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
      chk("i_ok", 64'(i_ok), 64'(ei));
      chk("d_ok", 64'(d_ok), 64'(ed));
      chk("m_valid", 64'(m_valid), 64'(owner != 0));
      if (owner != 0) begin
        chk("m_write", 64'(m_write), 64'(l_write));
        chk("m_addr", m_addr, l_addr);
        chk("m_size", 64'(m_size), 64'(l_size));
        chk("m_wdata", m_wdata, l_wdata);
        chk("m_strobe", 64'(m_strobe), 64'(l_strobe));
      end
      if (ei) chk("i_data", 64'(i_data), 64'(eword));
      if (ed) chk("d_rdata", d_rdata, m_rdata);
      if (i_ok) log_s = {log_s, "I"};
      if (d_ok) log_s = {log_s, "D"};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1; i_valid = 0; i_addr = 0;
    d_valid = 0; d_write = 0; d_addr = 0;
    d_size = 0; d_wdata = 0; d_strobe = 0;
    m_ok = 0; m_rdata = 0;
    step(); step();
    chk("rst m_valid", 64'(m_valid), 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst m_size", 64'(m_size), 0);
    chk("rst m_write", 64'(m_write), 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst m_strobe", 64'(m_strobe), 0);
    chk("rst i_ok", 64'(i_ok), 0);
    chk("rst d_ok", 64'(d_ok), 0);
    chk("rst i_data", 64'(i_data), 0);
    chk("rst d_rdata", d_rdata, 0);
    reset = 0;
    step();

    // Fetch only, upper lane, memory answers on 3rd busy cycle.
    i_valid = 1; i_addr = 64'h8000_0004;
    step();
    chk("f m_valid", 64'(m_valid), 1);
    chk("f m_addr", m_addr, 64'h8000_0004);
    chk("f m_size", 64'(m_size), 3);
    step(); step();
    m_ok = 1; m_rdata = 64'h1111_2222_3333_4444;
    #1;
    chk("f i_ok", 64'(i_ok), 1);
    chk("f i_data", 64'(i_data), 64'h1111_2222);
    step();
    m_ok = 0; i_valid = 0;

    // Simultaneous: store wins, then fetch from lower lane.
    i_valid = 1; i_addr = 64'h1000;
    d_valid = 1; d_write = 1; d_addr = 64'h100;
    d_size = 3; d_wdata = 64'hDEAD_BEEF; d_strobe = 8'h0F;
    step();
    chk("s m_write", 64'(m_write), 1);
    chk("s m_addr", m_addr, 64'h100);
    chk("s m_strobe", 64'(m_strobe), 64'h0F);
    chk("s m_wdata", m_wdata, 64'hDEAD_BEEF);
    m_ok = 1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("s d_ok", 64'(d_ok), 1);
    chk("s i_ok", 64'(i_ok), 0);
    step();
    m_ok = 0; d_valid = 0; d_write = 0;
    chk("s bubble", 64'(m_valid), 0);
    step();
    chk("s2 m_addr", m_addr, 64'h1000);
    chk("s2 m_write", 64'(m_write), 0);
    m_ok = 1;
    #1;
    chk("s2 i_data", 64'(i_data), 64'hCCCC_DDDD);
    step();
    m_ok = 0; i_valid = 0;

    // Starvation bound with both requesters always pending.
    log_s = "";
    i_valid = 1; i_addr = 64'h2000;
    d_valid = 1; d_addr = 64'h40; d_size = 4;
    for (int k = 0; k < 6; k++) begin
      step();
      m_ok = 1; m_rdata = 64'(k);
      step();
      m_ok = 0;
    end
    i_valid = 0; d_valid = 0;
    total++;
    if (log_s != "DDDDID") begin
      bad++;
      $display("FAIL starve order: got %s want DDDDID", log_s);
    end
    step();

    // Inputs change after grant; odd size is forwarded.
    d_valid = 1; d_addr = 64'h200; d_size = 7;
    step();
    d_addr = 64'h300; d_size = 1;
    step(); step();
    chk("mut m_addr", m_addr, 64'h200);
    chk("mut m_size", 64'(m_size), 7);
    m_ok = 1;
    step();
    m_ok = 0; d_valid = 0;
    step();

    // Reset in the middle of a fetch.
    i_valid = 1; i_addr = 64'h3000;
    step(); step();
    reset = 1;
    #1;
    chk("rm i_ok", 64'(i_ok), 0);
    step();
    reset = 0; i_valid = 0;
    chk("rm m_valid", 64'(m_valid), 0);
    d_valid = 1; d_write = 1; d_addr = 64'h500;
    d_size = 2; d_wdata = 64'h55; d_strobe = 8'h03;
    step();
    chk("rm2 m_valid", 64'(m_valid), 1);
    chk("rm2 m_addr", m_addr, 64'h500);
    m_ok = 1;
    #1;
    chk("rm2 d_ok", 64'(d_ok), 1);
    step();
    m_ok = 0; d_valid = 0; d_write = 0;

    // Spurious completion while idle.
    step();
    m_ok = 1; m_rdata = 64'hFFFF;
    #1;
    chk("sp i_ok", 64'(i_ok), 0);
    chk("sp d_ok", 64'(d_ok), 0);
    step();
    m_ok = 0;
    chk("sp m_valid", 64'(m_valid), 0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
